// File: rtl/ls367_bus_rx.sv
// ---------------------------------------------------------------------------
// ls367_bus_rx
//   Receive end of a tri-state board bus driven by ls367 hex buffers: a 4-bit
//   group 1 and a 2-bit group 2, each with its own active-low enable.
//   The bus pins are registered once. After a driver turns on, the block waits
//   for the enable set to stay stable for a settle window. It then captures one
//   6-bit word per drive frame. The word is offered to a consumer with a
//   valid/ack handshake. Bits of an undriven group report PULL_VAL instead of
//   the floating pin value.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous reset, active-high
//   g1_n       in   1      group 1 driver enable seen on bus (0 = driven)
//   g2_n       in   1      group 2 driver enable seen on bus (0 = driven)
//   y1         in   4      group 1 bus lines
//   y2         in   2      group 2 bus lines
//   rd_ack     in   1      consumer accepts data_q (only while valid=1)
//   data_q     out  6      captured word {y2,y1}
//   valid      out  1      data_q holds an unconsumed word
//   overrun    out  1      sticky: a word was overwritten before ack
//   float_1    out  1      group 1 undriven in captured frame
//   float_2    out  1      group 2 undriven in captured frame
//   abort_cnt  out  CNT_W  saturating count of frames aborted while settling
// ---------------------------------------------------------------------------
module ls367_bus_rx #(
  parameter int   SETTLE_CYC = 2,
  parameter logic PULL_VAL   = 1'b1,
  parameter int   CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             g1_n,
  input  logic             g2_n,
  input  logic [3:0]       y1,
  input  logic [1:0]       y2,
  input  logic             rd_ack,
  output logic [5:0]       data_q,
  output logic             valid,
  output logic             overrun,
  output logic             float_1,
  output logic             float_2,
  output logic [CNT_W-1:0] abort_cnt
);

  // Settle counter only needs to reach SETTLE_CYC-1.
  localparam int SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_HOLD
  } state_t;

  // Input stage registers
  logic             r_s_g1n;
  logic             r_s_g2n;
  logic [3:0]       r_s_y1;
  logic [1:0]       r_s_y2;

  // FSM and datapath registers
  state_t           r_state,     r_state_next;
  logic [SCNT_W-1:0] r_cnt,      r_cnt_next;
  logic [1:0]       r_mask,      r_mask_next;
  logic [5:0]       r_data_q,    r_data_q_next;
  logic             r_valid,     r_valid_next;
  logic             r_overrun,   r_overrun_next;
  logic             r_float_1,   r_float_1_next;
  logic             r_float_2,   r_float_2_next;
  logic [CNT_W-1:0] r_abort_cnt, r_abort_cnt_next;

  logic             w_en_any;
  logic [1:0]       w_mask;
  logic [5:0]       w_word;

  assign w_en_any = ~r_s_g1n | ~r_s_g2n;
  assign w_mask   = {r_s_g2n, r_s_g1n};
  // Undriven groups report the pull value so that floating pins never reach data_q.
  assign w_word[3:0] = r_s_g1n ? {4{PULL_VAL}} : r_s_y1;
  assign w_word[5:4] = r_s_g2n ? {2{PULL_VAL}} : r_s_y2;

  // Input stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_g1n <= 1'b1;
      r_s_g2n <= 1'b1;
      r_s_y1  <= '0;
      r_s_y2  <= '0;
    end else begin
      r_s_g1n <= g1_n;
      r_s_g2n <= g2_n;
      r_s_y1  <= y1;
      r_s_y2  <= y2;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_mask      <= 2'b11;
      r_data_q    <= {6{PULL_VAL}};
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_float_1   <= 1'b1;
      r_float_2   <= 1'b1;
      r_abort_cnt <= '0;
    end else begin
      r_state     <= r_state_next;
      r_cnt       <= r_cnt_next;
      r_mask      <= r_mask_next;
      r_data_q    <= r_data_q_next;
      r_valid     <= r_valid_next;
      r_overrun   <= r_overrun_next;
      r_float_1   <= r_float_1_next;
      r_float_2   <= r_float_2_next;
      r_abort_cnt <= r_abort_cnt_next;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    r_state_next     = r_state;
    r_cnt_next       = r_cnt;
    r_mask_next      = r_mask;
    r_data_q_next    = r_data_q;
    r_valid_next     = r_valid;
    r_overrun_next   = r_overrun;
    r_float_1_next   = r_float_1;
    r_float_2_next   = r_float_2;
    r_abort_cnt_next = r_abort_cnt;

    // Consumer handshake; a capture below takes precedence and re-asserts valid.
    if (r_valid && rd_ack) begin
      r_valid_next = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_en_any) begin
          r_state_next = ST_SETTLE;
          r_cnt_next   = '0;
          r_mask_next  = w_mask;
        end
      end

      ST_SETTLE: begin
        if (!w_en_any) begin
          r_state_next = ST_IDLE;
          if (r_abort_cnt != {CNT_W{1'b1}}) begin
            r_abort_cnt_next = r_abort_cnt + 1'b1;
          end
        end else if (w_mask != r_mask) begin
          // Enable set still moving: restart the settle window.
          r_cnt_next  = '0;
          r_mask_next = w_mask;
        end else if (r_cnt == SETTLE_LAST) begin
          r_state_next = ST_CAPTURE;
        end else begin
          r_cnt_next = r_cnt + 1'b1;
        end
      end

      ST_CAPTURE: begin
        r_data_q_next  = w_word;
        r_float_1_next = r_s_g1n;
        r_float_2_next = r_s_g2n;
        r_valid_next   = 1'b1;
        if (r_valid && !rd_ack) begin
          r_overrun_next = 1'b1;
        end
        r_state_next = ST_HOLD;
      end

      ST_HOLD: begin
        // One capture per frame: wait for the bus to go fully undriven.
        if (!w_en_any) begin
          r_state_next = ST_IDLE;
        end
      end

      default: begin
        r_state_next = ST_IDLE;
      end
    endcase
  end

  assign data_q    = r_data_q;
  assign valid     = r_valid;
  assign overrun   = r_overrun;
  assign float_1   = r_float_1;
  assign float_2   = r_float_2;
  assign abort_cnt = r_abort_cnt;

endmodule

// File: tb/tb_ls367_bus_rx.sv
// ---------------------------------------------------------------------------
// tb_ls367_bus_rx
//   Directed bench for ls367_bus_rx with default parameters. Inputs are
//   driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ls367_bus_rx;

  logic       clk;
  logic       rst;
  logic       g1_n;
  logic       g2_n;
  logic [3:0] y1;
  logic [1:0] y2;
  logic       rd_ack;
  logic [5:0] data_q;
  logic       valid;
  logic       overrun;
  logic       float_1;
  logic       float_2;
  logic [7:0] abort_cnt;

  int n_checks = 0;
  int n_errors = 0;

  ls367_bus_rx dut (
    .clk       (clk),
    .rst       (rst),
    .g1_n      (g1_n),
    .g2_n      (g2_n),
    .y1        (y1),
    .y2        (y2),
    .rd_ack    (rd_ack),
    .data_q    (data_q),
    .valid     (valid),
    .overrun   (overrun),
    .float_1   (float_1),
    .float_2   (float_2),
    .abort_cnt (abort_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-22s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Drop both enables and acknowledge, then let the FSM return to IDLE.
  task automatic release_frame();
    g1_n   = 1'b1;
    g2_n   = 1'b1;
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    step(2);
  endtask

  initial begin
    rst = 1'b1; g1_n = 1'b1; g2_n = 1'b1; y1 = 4'h0; y2 = 2'b00; rd_ack = 1'b0;
    step(2);
    check("rst_data_q",   32'(data_q),    32'h3F);
    check("rst_valid",    32'(valid),     32'h0);
    check("rst_overrun",  32'(overrun),   32'h0);
    check("rst_floats",   32'({float_2, float_1}), 32'h3);
    check("rst_abort",    32'(abort_cnt), 32'h0);

    // Test 1: both groups driven
    rst = 1'b0; g1_n = 1'b0; g2_n = 1'b0; y1 = 4'b0001; y2 = 2'b00;
    step(4);
    check("t1_valid_edge3", 32'(valid), 32'h0);
    step(1);
    check("t1_valid_edge4", 32'(valid),  32'h1);
    check("t1_data_q",      32'(data_q), 32'h01);
    check("t1_floats",      32'({float_2, float_1}), 32'h0);
    g1_n = 1'b1; g2_n = 1'b1; rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    check("t1_ack_valid", 32'(valid), 32'h0);
    step(2);

    // Test 2: only group 2 driven; group 1 reports pull value
    g1_n = 1'b1; g2_n = 1'b0; y1 = 4'b0101; y2 = 2'b10;
    step(5);
    check("t2_valid",  32'(valid),  32'h1);
    check("t2_data_q", 32'(data_q), 32'h2F);
    check("t2_floats", 32'({float_2, float_1}), 32'h1);
    release_frame();

    // Test 3: one-cycle enable pulses abort in SETTLE
    g1_n = 1'b0; y1 = 4'b1010;
    step(1);
    g1_n = 1'b1;
    step(3);
    check("t3_abort_1", 32'(abort_cnt), 32'h1);
    check("t3_no_valid", 32'(valid), 32'h0);
    for (int i = 0; i < 254; i++) begin
      g1_n = 1'b0; step(1); g1_n = 1'b1; step(3);
    end
    check("t3_abort_255", 32'(abort_cnt), 32'hFF);
    g1_n = 1'b0; step(1); g1_n = 1'b1; step(3);
    check("t3_abort_sat", 32'(abort_cnt), 32'hFF);
    check("t3_no_valid2", 32'(valid), 32'h0);

    // Test 4: two frames without ack -> overrun
    g1_n = 1'b0; g2_n = 1'b0; y1 = 4'b0001; y2 = 2'b00;
    step(5);
    g1_n = 1'b1; g2_n = 1'b1;
    step(3);
    g1_n = 1'b0; g2_n = 1'b0; y1 = 4'b0010;
    step(5);
    check("t4_valid",   32'(valid),   32'h1);
    check("t4_overrun", 32'(overrun), 32'h1);
    check("t4_data_q",  32'(data_q),  32'h02);
    g1_n = 1'b1; g2_n = 1'b1; rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    check("t4_ack_valid",   32'(valid),   32'h0);
    check("t4_ack_overrun", 32'(overrun), 32'h1);
    step(2);

    // Test 5: ack on the CAPTURE cycle of a second frame
    rst = 1'b1; step(2); rst = 1'b0; step(1);
    g1_n = 1'b0; g2_n = 1'b0; y1 = 4'b0011; y2 = 2'b01;
    step(5);
    check("t5_f1_data_q", 32'(data_q), 32'h13);
    g1_n = 1'b1; g2_n = 1'b1;
    step(3);
    g1_n = 1'b0; g2_n = 1'b0; y1 = 4'b1100; y2 = 2'b10;
    step(4);
    check("t5_pre_data_q", 32'(data_q), 32'h13);
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    check("t5_valid",   32'(valid),   32'h1);
    check("t5_data_q",  32'(data_q),  32'h2C);
    check("t5_overrun", 32'(overrun), 32'h0);
    step(1);
    check("t5_valid_kept", 32'(valid), 32'h1);
    release_frame();

    // Test 6: reset during SETTLE with enables held low
    g1_n = 1'b0; step(1); g1_n = 1'b1; step(3);
    check("t6_abort_pre", 32'(abort_cnt), 32'h1);
    g1_n = 1'b0; g2_n = 1'b0; y1 = 4'b0110; y2 = 2'b11;
    step(2);
    rst = 1'b1;
    step(1);
    check("t6_rst_abort",  32'(abort_cnt), 32'h0);
    check("t6_rst_valid",  32'(valid),     32'h0);
    check("t6_rst_data_q", 32'(data_q),    32'h3F);
    check("t6_rst_floats", 32'({float_2, float_1}), 32'h3);
    rst = 1'b0;
    step(4);
    check("t6_valid_edge3", 32'(valid), 32'h0);
    step(1);
    check("t6_valid_edge4", 32'(valid),     32'h1);
    check("t6_data_q",      32'(data_q),    32'h36);
    check("t6_floats",      32'({float_2, float_1}), 32'h0);
    check("t6_abort_post",  32'(abort_cnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
